// File: rtl/wrap_timer.sv
// wrap_timer: counts upstream 4-bit counter wraps up to a latched limit, raises a sticky IRQ
// with ACK handshake and drives a registered 16-step PWM. Option macro: WRAP_TIMER_AUTORELOAD_EN.
module wrap_timer #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             ASYNCRESET,
  input  logic             COUT,
  input  logic [3:0]       I,
  input  logic             START,
  input  logic             STOP,
  input  logic             ACK,
  input  logic [WIDTH-1:0] LIMIT,
  input  logic [3:0]       DUTY,
  output logic             BUSY,
  output logic             IRQ,
  output logic [WIDTH-1:0] COUNT,
  output logic             PWM
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] limit_r;
  logic [WIDTH-1:0] limit_nxt_s;
  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] count_nxt_s;
  logic [WIDTH-1:0] count_inc_s;
  logic [3:0]       duty_r;
  logic [3:0]       duty_nxt_s;
  logic             busy_r;
  logic             irq_r;
  logic             irq_nxt_s;
  logic             irq_set_s;
  logic             irq_clr_s;
  logic             pwm_r;
  logic             pwm_nxt_s;
  logic             terminal_s;

  assign count_inc_s = count_r + {{(WIDTH-1){1'b0}}, 1'b1};
  assign terminal_s  = COUT && (count_inc_s == limit_r);

  // State register
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; STOP outranks a terminal wrap in RUN
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (START) begin
          if (LIMIT == {WIDTH{1'b0}}) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (STOP) begin
          state_nxt_s = ST_IDLE;
        end else if (terminal_s) begin
`ifdef WRAP_TIMER_AUTORELOAD_EN
          state_nxt_s = ST_RUN;
`else
          state_nxt_s = ST_DONE;
`endif
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (ACK) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs and latched configuration
  always_comb begin
    limit_nxt_s = limit_r;
    duty_nxt_s  = duty_r;
    count_nxt_s = count_r;
    irq_set_s   = 1'b0;
    pwm_nxt_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (START) begin
          limit_nxt_s = LIMIT;
          duty_nxt_s  = DUTY;
          count_nxt_s = {WIDTH{1'b0}};
          irq_set_s   = (LIMIT == {WIDTH{1'b0}});
        end else begin
          irq_set_s   = 1'b0;
        end
      end
      ST_RUN: begin
        pwm_nxt_s = (I < duty_r);
        if (STOP) begin
          count_nxt_s = count_r;
        end else if (terminal_s) begin
          irq_set_s = 1'b1;
`ifdef WRAP_TIMER_AUTORELOAD_EN
          count_nxt_s = {WIDTH{1'b0}};
`else
          count_nxt_s = count_inc_s;
`endif
        end else if (COUT) begin
          count_nxt_s = count_inc_s;
        end else begin
          count_nxt_s = count_r;
        end
      end
      ST_DONE: begin
        count_nxt_s = count_r;
      end
      default: begin
        count_nxt_s = {WIDTH{1'b0}};
      end
    endcase

    // A set in the same cycle as ACK leaves IRQ high
`ifdef WRAP_TIMER_AUTORELOAD_EN
    irq_clr_s = ACK;
`else
    irq_clr_s = ACK && (state_r == ST_DONE);
`endif
    if (irq_set_s) begin
      irq_nxt_s = 1'b1;
    end else if (irq_clr_s) begin
      irq_nxt_s = 1'b0;
    end else begin
      irq_nxt_s = irq_r;
    end
  end

  // Output and configuration registers
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      limit_r <= {WIDTH{1'b0}};
      duty_r  <= 4'd0;
      count_r <= {WIDTH{1'b0}};
      busy_r  <= 1'b0;
      irq_r   <= 1'b0;
      pwm_r   <= 1'b0;
    end else begin
      limit_r <= limit_nxt_s;
      duty_r  <= duty_nxt_s;
      count_r <= count_nxt_s;
      busy_r  <= (state_nxt_s == ST_RUN);
      irq_r   <= irq_nxt_s;
      pwm_r   <= pwm_nxt_s;
    end
  end

  assign BUSY  = busy_r;
  assign IRQ   = irq_r;
  assign COUNT = count_r;
  assign PWM   = pwm_r;

endmodule

// File: tb/tb_wrap_timer.sv
// Self-checking bench for wrap_timer: directed scenarios plus randomized control traffic
// against a wrap-counting reference model.
`timescale 1ns/1ps
module tb_wrap_timer;
  localparam int WIDTH = 8;
`ifdef WRAP_TIMER_AUTORELOAD_EN
  localparam bit AUTO_EN = 1'b1;
`else
  localparam bit AUTO_EN = 1'b0;
`endif
  localparam int P_IDLE = 0;
  localparam int P_RUN  = 1;
  localparam int P_DONE = 2;

  logic             CLK = 1'b0;
  logic             ASYNCRESET;
  logic             COUT;
  logic [3:0]       I;
  logic             START;
  logic             STOP;
  logic             ACK;
  logic [WIDTH-1:0] LIMIT;
  logic [3:0]       DUTY;
  logic             BUSY;
  logic             IRQ;
  logic [WIDTH-1:0] COUNT;
  logic             PWM;

  logic [3:0] up_cnt;
  bit         cmp_en = 1'b0;
  int         chk_cnt = 0;
  int         pass_cnt = 0;

  always #5 CLK = ~CLK;

  wrap_timer #(.WIDTH(WIDTH)) dut (
    .CLK(CLK), .ASYNCRESET(ASYNCRESET), .COUT(COUT), .I(I), .START(START), .STOP(STOP),
    .ACK(ACK), .LIMIT(LIMIT), .DUTY(DUTY), .BUSY(BUSY), .IRQ(IRQ), .COUNT(COUNT), .PWM(PWM)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: counts wraps since START; COUNT is derived from that total
  int         m_phase;
  int         m_lim;
  int         m_wraps;
  logic [3:0] m_duty;
  logic       m_irq;
  logic       m_pwm;
  logic       m_set;

  assign m_set = (m_phase == P_IDLE && START && LIMIT == '0) ||
                 (m_phase == P_RUN && !STOP && COUT && m_lim != 0 &&
                  (AUTO_EN ? ((m_wraps + 1) % m_lim == 0) : (m_wraps + 1 == m_lim)));

  function automatic logic [WIDTH-1:0] exp_count();
    if (AUTO_EN && m_lim != 0) return WIDTH'(m_wraps % m_lim);
    return WIDTH'(m_wraps);
  endfunction

  always @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      m_phase <= P_IDLE; m_lim <= 0; m_wraps <= 0; m_duty <= 4'd0; m_irq <= 1'b0; m_pwm <= 1'b0;
    end else begin
      m_pwm <= (m_phase == P_RUN) && (I < m_duty);
      if (m_set) m_irq <= 1'b1;
      else if (ACK && (AUTO_EN || m_phase == P_DONE)) m_irq <= 1'b0;
      if (m_phase == P_IDLE) begin
        if (START) begin
          m_lim <= int'(LIMIT); m_duty <= DUTY; m_wraps <= 0;
          m_phase <= (LIMIT == '0) ? P_DONE : P_RUN;
        end
      end else if (m_phase == P_RUN) begin
        if (STOP) m_phase <= P_IDLE;
        else if (COUT) begin
          m_wraps <= m_wraps + 1;
          if (!AUTO_EN && m_wraps + 1 == m_lim) m_phase <= P_DONE;
        end
      end else begin
        if (ACK) m_phase <= P_IDLE;
      end
    end
  end

  // Every-cycle comparison away from the active edge
  always @(negedge CLK) begin
    if (cmp_en) begin
      check("m_busy", BUSY, m_phase == P_RUN);
      check("m_irq", IRQ, m_irq);
      check("m_count", COUNT, exp_count());
      check("m_pwm", PWM, m_pwm);
    end
  end

  task automatic cyc();
    @(negedge CLK);
    up_cnt = up_cnt + 4'd1;
    I = up_cnt;
    COUT = (up_cnt == 4'hf);
  endtask

  task automatic pulse_reset(input string tag);
    #2 ASYNCRESET = 1'b1;
    #1;
    check({tag, "_busy"}, BUSY, 0);
    check({tag, "_irq"}, IRQ, 0);
    check({tag, "_count"}, COUNT, 0);
    check({tag, "_pwm"}, PWM, 0);
    cyc();
    ASYNCRESET = 1'b0;
  endtask

  task automatic settle();
    STOP = 1'b1; cyc(); STOP = 1'b0;
    ACK = 1'b1; cyc(); ACK = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] prev;
    int nseen, highs, ncout;
    bit got, found, irq_seen;
    ASYNCRESET = 1'b1; START = 1'b0; STOP = 1'b0; ACK = 1'b0;
    LIMIT = '0; DUTY = 4'd0; up_cnt = 4'd0; I = 4'd0; COUT = 1'b0;
    repeat (3) cyc();
    ASYNCRESET = 1'b0;
    cmp_en = 1'b1;
    repeat (3) cyc();
    check("rst_busy", BUSY, 0); check("rst_irq", IRQ, 0);
    check("rst_count", COUNT, 0); check("rst_pwm", PWM, 0);

    // Reset in the middle of a run discards it
    START = 1'b1; LIMIT = 8'd3; DUTY = 4'd9; cyc(); START = 1'b0;
    repeat (20) cyc();
    pulse_reset("midrst");

`ifndef WRAP_TIMER_AUTORELOAD_EN
    START = 1'b1; LIMIT = 8'd3; DUTY = 4'd4; cyc(); START = 1'b0;
    check("os_busy", BUSY, 1); check("os_count0", COUNT, 0);
    prev = COUNT; nseen = 0; highs = 0; got = 1'b0;
    for (int t = 0; t < 80 && !got; t++) begin
      cyc();
      if (t >= 1 && t < 17) highs += int'(PWM);
      if (COUNT != prev) begin
        nseen++;
        check("os_step", COUNT, nseen);
        if (nseen == 3) check("os_irq_at_3", IRQ, 1);
        prev = COUNT;
      end
      if (IRQ) begin
        got = 1'b1;
        check("os_irq_count", COUNT, 3); check("os_irq_busy", BUSY, 0);
      end
    end
    check("os_irq_seen", got, 1);
    check("pwm_duty4_highs", highs, 4);
    cyc(); check("pwm_after_irq", PWM, 0);
    ACK = 1'b1; cyc(); ACK = 1'b0;
    check("ack_irq", IRQ, 0); check("ack_busy", BUSY, 0);
`else
    START = 1'b1; LIMIT = 8'd2; DUTY = 4'd8; cyc(); START = 1'b0;
    got = 1'b0;
    for (int t = 0; t < 60 && !got; t++) begin
      cyc();
      if (IRQ) got = 1'b1;
    end
    check("ar_irq_seen", got, 1); check("ar_count0", COUNT, 0); check("ar_busy", BUSY, 1);
    ncout = 0;
    for (int t = 0; t < 80 && ncout < 2; t++) begin
      cyc();
      if (COUT) ncout++;
    end
    cyc();
    check("ar_two_more", ncout, 2); check("ar_irq_sticky", IRQ, 1);
    check("ar_count_4th", COUNT, 0); check("ar_busy2", BUSY, 1);
    ACK = 1'b1; cyc(); ACK = 1'b0;
    check("ar_ack_irq", IRQ, 0); check("ar_ack_busy", BUSY, 1);
`endif
    settle();

    // Zero limit, then START together with ACK in DONE
    START = 1'b1; LIMIT = 8'd0; cyc(); START = 1'b0;
    check("z_irq", IRQ, 1); check("z_count", COUNT, 0); check("z_busy", BUSY, 0);
    START = 1'b1; ACK = 1'b1; cyc(); START = 1'b0; ACK = 1'b0;
    check("z_ack_irq", IRQ, 0); check("z_ack_busy", BUSY, 0);
    cyc(); check("z_start_ignored", BUSY, 0);

    // STOP on the second wrap wins over the terminal count
    START = 1'b1; LIMIT = 8'd2; DUTY = 4'd15; cyc(); START = 1'b0;
    irq_seen = 1'b0; found = 1'b0;
    for (int t = 0; t < 60 && !found; t++) begin
      cyc();
      irq_seen |= IRQ;
      if (COUT && COUNT == 8'd1) begin
        STOP = 1'b1; cyc(); STOP = 1'b0; found = 1'b1;
      end
    end
    irq_seen |= IRQ;
    check("ab_found", found, 1); check("ab_busy", BUSY, 0);
    check("ab_count", COUNT, 1); check("ab_no_irq", irq_seen, 0);

    // Duty 0 never drives PWM high
    START = 1'b1; LIMIT = 8'd1; DUTY = 4'd0; cyc(); START = 1'b0;
    highs = 0;
    for (int t = 0; t < 20; t++) begin
      cyc();
      highs += int'(PWM);
    end
    check("pwm_duty0", highs, 0);
    settle();

    for (int t = 0; t < 3000; t++) begin
      cyc();
      ASYNCRESET = 1'b0;
      START = ($urandom_range(0, 7) == 0);
      STOP  = ($urandom_range(0, 63) == 0);
      ACK   = ($urandom_range(0, 5) == 0);
      LIMIT = WIDTH'($urandom_range(0, 4));
      DUTY  = 4'($urandom);
      if ($urandom_range(0, 499) == 0) #2 ASYNCRESET = 1'b1;
    end
    cyc();
    ASYNCRESET = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
